// File: rtl/weight_buffer_pingpong_if.sv
// rtl/weight_buffer_pingpong_if.sv - load stream, read port and bank-control signals of the ping-pong weight buffer
interface weight_buffer_pingpong_if #(
  parameter int DATA_WIDTH = 32,
  parameter int PSYS       = 24,
  parameter int LOAD_LANES = 4,
  parameter int ADDR_W     = 12
);
  logic                             load_valid;
  logic                             load_ready;
  logic [LOAD_LANES*DATA_WIDTH-1:0] load_data;
  logic                             load_last;
  logic                             rd_en;
  logic [ADDR_W-1:0]                rd_addr;
  logic                             rd_valid;
  logic [PSYS*DATA_WIDTH-1:0]       rd_data;
  logic                             swap;
  logic                             shadow_full;
  logic                             active_bank;

  modport master (
    output load_valid, load_data, load_last, rd_en, rd_addr, swap,
    input  load_ready, rd_valid, rd_data, shadow_full, active_bank
  );

  modport slave (
    input  load_valid, load_data, load_last, rd_en, rd_addr, swap,
    output load_ready, rd_valid, rd_data, shadow_full, active_bank
  );
endinterface

// File: rtl/weight_buffer_pingpong.sv
// rtl/weight_buffer_pingpong.sv - two-bank weight store: shadow bank packed from a beat stream, active bank read with 2-cycle latency
module weight_buffer_pingpong #(
  parameter int DATA_WIDTH  = 32,
  parameter int FEATURE_LEN = 256,
  parameter int PSYS        = 24,
  parameter int LOAD_LANES  = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  weight_buffer_pingpong_if.slave   bus
);
  localparam int TOTAL      = FEATURE_LEN * FEATURE_LEN;
  localparam int DEPTH      = (TOTAL + PSYS - 1) / PSYS;
  localparam int ADDR_W     = $clog2(DEPTH);
  localparam int BEATS      = PSYS / LOAD_LANES;
  localparam int BEAT_W     = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int ROW_W      = PSYS * DATA_WIDTH;
  localparam int BEAT_BITS  = LOAD_LANES * DATA_WIDTH;
  localparam int LAST_ELEMS = TOTAL - (DEPTH - 1) * PSYS;
  localparam int LAST_BEATS = (LAST_ELEMS + LOAD_LANES - 1) / LOAD_LANES;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  if (PSYS % LOAD_LANES != 0) begin : g_lane_check
    $error("PSYS must be a multiple of LOAD_LANES");
  end

  typedef enum logic {S_FILL, S_FULL} state_t;

  state_t            state;
  logic              load_ready_q;
  logic              shadow_full_q;
  logic              active_q;
  logic [ADDR_W-1:0] wr_row;
  logic [BEAT_W-1:0] beat_cnt;
  logic [ROW_W-1:0]  row_buf;

  logic [ROW_W-1:0]  bank0 [DEPTH];
  logic [ROW_W-1:0]  bank1 [DEPTH];

  logic              xfer;
  logic              last_row;
  logic              row_done;
  logic              go_full;
  logic [ROW_W-1:0]  row_next;
  logic [ROW_W-1:0]  wdata;

  always_comb begin
    xfer     = bus.load_valid && load_ready_q;
    last_row = (wr_row == ADDR_W'(DEPTH - 1));
    row_done = xfer && (bus.load_last || (beat_cnt == BEAT_W'(BEATS - 1)) ||
                        (last_row && (beat_cnt == BEAT_W'(LAST_BEATS - 1))));
    go_full  = xfer && (bus.load_last || (last_row && row_done));

    row_next = row_buf;
    for (int k = 0; k < BEATS; k++) begin
      if (beat_cnt == BEAT_W'(k)) begin
        row_next[k*BEAT_BITS +: BEAT_BITS] = bus.load_data;
      end
    end

    // The final row of the matrix only partly holds real elements.
    wdata = row_next;
    for (int i = 0; i < PSYS; i++) begin
      if (last_row && (i >= LAST_ELEMS)) begin
        wdata[i*DATA_WIDTH +: DATA_WIDTH] = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= S_FILL;
      load_ready_q  <= 1'b0;
      shadow_full_q <= 1'b0;
      active_q      <= 1'b0;
      wr_row        <= '0;
      beat_cnt      <= '0;
      row_buf       <= '0;
    end else begin
      case (state)
        S_FILL: begin
          load_ready_q <= 1'b1;
          if (xfer) begin
            if (row_done) begin
              row_buf  <= '0;
              beat_cnt <= '0;
              wr_row   <= wr_row + 1'b1;
            end else begin
              row_buf  <= row_next;
              beat_cnt <= beat_cnt + 1'b1;
            end
            if (go_full) begin
              state         <= S_FULL;
              load_ready_q  <= 1'b0;
              shadow_full_q <= 1'b1;
            end
          end
        end
        S_FULL: begin
          if (bus.swap) begin
            state         <= S_FILL;
            active_q      <= ~active_q;
            shadow_full_q <= 1'b0;
            load_ready_q  <= 1'b1;
            wr_row        <= '0;
            beat_cnt      <= '0;
            row_buf       <= '0;
          end
        end
        default: state <= S_FILL;
      endcase
    end
  end

  // Bank contents survive reset, so the arrays have no reset branch.
  always_ff @(posedge clk) begin
    if (row_done && !active_q) bank1[wr_row] <= wdata;
    if (row_done && active_q)  bank0[wr_row] <= wdata;
  end

  logic              rd_v1, rd_v2, rd_valid_q;
  logic              sel1, sel2;
  logic              oob1, oob2;
  logic [ADDR_W-1:0] addr1;
  logic [ROW_W-1:0]  q0, q1;
  logic [ROW_W-1:0]  rd_data_q;
  logic              oob_in;

  assign oob_in = ({1'b0, bus.rd_addr} >= DEPTH_L);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_v1      <= 1'b0;
      rd_v2      <= 1'b0;
      rd_valid_q <= 1'b0;
      sel1       <= 1'b0;
      sel2       <= 1'b0;
      oob1       <= 1'b0;
      oob2       <= 1'b0;
      addr1      <= '0;
      rd_data_q  <= '0;
    end else begin
      rd_v1      <= bus.rd_en;
      sel1       <= active_q;
      oob1       <= oob_in;
      addr1      <= oob_in ? '0 : bus.rd_addr;
      rd_v2      <= rd_v1;
      sel2       <= sel1;
      oob2       <= oob1;
      rd_valid_q <= rd_v2;
      rd_data_q  <= (oob2 || !rd_v2) ? '0 : (sel2 ? q1 : q0);
    end
  end

  always_ff @(posedge clk) begin
    q0 <= bank0[addr1];
    q1 <= bank1[addr1];
  end

  assign bus.load_ready  = load_ready_q;
  assign bus.shadow_full = shadow_full_q;
  assign bus.active_bank = active_q;
  assign bus.rd_valid    = rd_valid_q;
  assign bus.rd_data     = rd_data_q;
endmodule

// File: tb/tb_weight_buffer_pingpong.sv
// tb/tb_weight_buffer_pingpong.sv - directed stimulus with a read scoreboard for weight_buffer_pingpong
module tb_weight_buffer_pingpong;
  localparam int DW        = 32;
  localparam int FL        = 256;
  localparam int PSYS      = 24;
  localparam int LL        = 4;
  localparam int ADDR_W    = 12;
  localparam int TOTAL     = FL * FL;
  localparam int ROW_W     = PSYS * DW;
  localparam int BEAT_BITS = LL * DW;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [ROW_W-1:0] data;
    int               due;
    int               id;
  } exp_t;

  exp_t sbq[$];
  int   rd_id = 0;

  weight_buffer_pingpong_if #(.DATA_WIDTH(DW), .PSYS(PSYS), .LOAD_LANES(LL), .ADDR_W(ADDR_W)) bus ();

  weight_buffer_pingpong #(.DATA_WIDTH(DW), .FEATURE_LEN(FL), .PSYS(PSYS), .LOAD_LANES(LL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      if (bus.rd_valid) begin
        n_tests++;
        if (sbq.size() == 0) begin
          n_fail++;
          $display("FAIL rd_unexpected cyc=%0d got rd_valid=1 required 0", cyc);
        end else begin
          e = sbq.pop_front();
          if (bus.rd_data !== e.data || cyc != e.due) begin
            n_fail++;
            $display("FAIL rd_%0d got=%h at cyc %0d required=%h at cyc %0d",
                     e.id, bus.rd_data, cyc, e.data, e.due);
          end
        end
      end else if (sbq.size() > 0 && sbq[0].due <= cyc) begin
        n_tests++;
        n_fail++;
        $display("FAIL rd_missing_%0d got rd_valid=0 required 1 at cyc %0d", sbq[0].id, sbq[0].due);
        void'(sbq.pop_front());
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [BEAT_BITS-1:0] seq_beat(input int base);
    logic [BEAT_BITS-1:0] d;
    for (int l = 0; l < LL; l++) d[l*DW +: DW] = DW'(base + l);
    return d;
  endfunction

  function automatic logic [ROW_W-1:0] full_row(input int r);
    logic [ROW_W-1:0] row;
    for (int j = 0; j < PSYS; j++) begin
      int e;
      e = r * PSYS + j;
      row[j*DW +: DW] = (e < TOTAL) ? DW'(e) : '0;
    end
    return row;
  endfunction

  function automatic logic [ROW_W-1:0] part_row(input int base, input int n);
    logic [ROW_W-1:0] row;
    for (int j = 0; j < PSYS; j++) row[j*DW +: DW] = (j < n) ? DW'(base + j) : '0;
    return row;
  endfunction

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [BEAT_BITS-1:0] d, input logic last);
    int guard;
    guard = 0;
    bus.load_valid = 1'b1;
    bus.load_data  = d;
    bus.load_last  = last;
    while (!bus.load_ready && guard < 100) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (guard >= 100) begin
      n_tests++;
      n_fail++;
      $display("FAIL beat_timeout got load_ready=0 required 1");
    end
    @(posedge clk);
    #1;
    bus.load_valid = 1'b0;
    bus.load_last  = 1'b0;
  endtask

  task automatic rd(input int addr, input logic [ROW_W-1:0] exp, input logic sw);
    exp_t e;
    bus.rd_en   = 1'b1;
    bus.rd_addr = ADDR_W'(addr);
    bus.swap    = sw;
    e.data = exp;
    e.due  = cyc + 3;
    e.id   = rd_id++;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    bus.rd_en = 1'b0;
    bus.swap  = 1'b0;
  endtask

  task automatic pulse_swap();
    bus.swap = 1'b1;
    @(posedge clk);
    #1;
    bus.swap = 1'b0;
  endtask

  initial begin
    bus.load_valid = 1'b0;
    bus.load_data  = '0;
    bus.load_last  = 1'b0;
    bus.rd_en      = 1'b0;
    bus.rd_addr    = '0;
    bus.swap       = 1'b0;

    idle(3);
    check("rst_load_ready", bus.load_ready, 0);
    check("rst_shadow_full", bus.shadow_full, 0);
    check("rst_active_bank", bus.active_bank, 0);
    check("rst_rd_valid", bus.rd_valid, 0);
    check("rst_rd_data", {63'b0, |bus.rd_data}, 0);
    #2 rst = 1'b1;
    @(posedge clk);
    #1;
    check("release_load_ready", bus.load_ready, 1);

    for (int b = 0; b < 6; b++) beat(seq_beat(4 * b), 1'b0);
    check("row0_shadow_full", bus.shadow_full, 0);
    check("row0_load_ready", bus.load_ready, 1);

    for (int b = 6; b < TOTAL / LL; b++) begin
      beat(seq_beat(4 * b), 1'b0);
      if (b == TOTAL / LL - 2) check("pre_last_shadow_full", bus.shadow_full, 0);
    end
    check("full_shadow_full", bus.shadow_full, 1);
    check("full_load_ready", bus.load_ready, 0);

    pulse_swap();
    check("swap_active_bank", bus.active_bank, 1);
    check("swap_shadow_full", bus.shadow_full, 0);
    check("swap_load_ready", bus.load_ready, 1);
    rd(0, full_row(0), 1'b0);
    rd(1, full_row(1), 1'b0);
    rd(2730, full_row(2730), 1'b0);
    rd(2731, '0, 1'b0);
    idle(4);

    pulse_swap();
    check("fill_swap_active_bank", bus.active_bank, 1);
    check("fill_swap_shadow_full", bus.shadow_full, 0);
    for (int k = 0; k < 4; k++) beat(seq_beat(1000 + 4 * k), k == 3);
    check("last_shadow_full", bus.shadow_full, 1);
    check("last_load_ready", bus.load_ready, 0);

    rd(0, full_row(0), 1'b0);
    rd(1, full_row(1), 1'b1);
    rd(4095, '0, 1'b0);
    check("b2b_active_bank", bus.active_bank, 0);
    check("b2b_shadow_full", bus.shadow_full, 0);
    idle(4);
    rd(0, part_row(1000, 16), 1'b0);
    idle(4);

    beat(seq_beat(7000), 1'b1);
    check("one_beat_shadow_full", bus.shadow_full, 1);
    pulse_swap();
    check("one_beat_active_bank", bus.active_bank, 1);
    rd(0, part_row(7000, 4), 1'b0);
    idle(4);

    for (int k = 0; k < 3; k++) beat(seq_beat(9000 + 4 * k), 1'b0);
    rd(5, full_row(5), 1'b0);
    idle(2);
    bus.load_valid = 1'b1;
    bus.load_data  = seq_beat(9012);
    #1;
    rst = 1'b0;
    sbq.delete();
    #1;
    check("async_rd_valid", bus.rd_valid, 0);
    check("async_rd_data", {63'b0, |bus.rd_data}, 0);
    check("async_active_bank", bus.active_bank, 0);
    check("async_shadow_full", bus.shadow_full, 0);
    check("async_load_ready", bus.load_ready, 0);
    bus.load_valid = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    @(posedge clk);
    #1;
    check("rerelease_load_ready", bus.load_ready, 1);
    check("rerelease_active_bank", bus.active_bank, 0);
    rd(0, part_row(1000, 16), 1'b0);
    idle(5);

    if (sbq.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL sb_leftover got=%0d entries required=0", sbq.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/weight_buffer_pingpong.md
WEIGHT_BUFFER_PINGPONG -- requirements
Module: weight_buffer_pingpong

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, bits per weight element.
REQ-002 SHALL have parameter FEATURE_LEN, default 256, weight matrix dimension (FEATURE_LEN x FEATURE_LEN).
REQ-003 SHALL have parameter PSYS, default 24, elements per buffer row (systolic width).
REQ-004 SHALL have parameter LOAD_LANES, default 4, elements per load beat; PSYS % LOAD_LANES == 0 required, else elaboration error.
REQ-005 SHALL derive DEPTH = ceil(FEATURE_LEN*FEATURE_LEN/PSYS) (2731 at defaults), ADDR_W = $clog2(DEPTH) (12), BEATS = PSYS/LOAD_LANES (6).
REQ-006 clk  input  1  sole clock; all logic rising-edge.
REQ-007 rst  input  1  asynchronous, active-low reset.
REQ-008 load_valid  input  1  load beat valid.
REQ-009 load_ready  output  1  loader accepts beat.
REQ-010 load_data  input  LOAD_LANES*DATA_WIDTH  load elements, lane 0 in LSBs.
REQ-011 load_last  input  1  final beat of matrix, qualified by load_valid.
REQ-012 rd_en  input  1  read request.
REQ-013 rd_addr  input  ADDR_W  row to read from active bank.
REQ-014 rd_valid  output  1  rd_data valid.
REQ-015 rd_data  output  PSYS*DATA_WIDTH  row read, element 0 in LSBs.
REQ-016 swap  input  1  single-cycle request to exchange banks.
REQ-017 shadow_full  output  1  shadow bank holds a complete matrix.
REQ-018 active_bank  output  1  index (0/1) of bank serving reads.

Function
REQ-019 SHALL hold two banks, each DEPTH rows x PSYS*DATA_WIDTH bits; reads use active bank, loads target shadow bank (!active_bank).
REQ-020 Loader FSM SHALL have states FILL and FULL; FILL on reset.
REQ-021 In FILL, load_ready SHALL be 1; a beat transfers when load_valid && load_ready.
REQ-022 Packer SHALL place beat k (0..BEATS-1) into lanes k*LOAD_LANES..k*LOAD_LANES+LOAD_LANES-1 of a row register; on beat BEATS-1 the row SHALL be written to shadow bank at wr_row, wr_row increments, beat counter returns to 0.
REQ-023 On transferred beat with load_last=1 the partially filled row SHALL be written with unfilled lanes zero, and FSM SHALL go to FULL.
REQ-024 When row DEPTH-1 is written (no load_last), FSM SHALL go to FULL; the tail of that row beyond FEATURE_LEN*FEATURE_LEN elements SHALL be zero.
REQ-025 In FULL, load_ready SHALL be 0 and shadow_full SHALL be 1.
REQ-026 swap while FULL SHALL toggle active_bank on that edge, clear shadow_full, reset wr_row and beat counter to 0, and return FSM to FILL; load_ready=1 from next cycle.
REQ-027 swap while FILL SHALL be ignored (no toggle, no state change).
REQ-028 Reads SHALL be fully pipelined, one per cycle: rd_en sampled at edge N yields rd_valid=1 and rd_data after edge N+2 (latency 2).
REQ-029 Read bank SHALL be the active_bank value before edge N; a swap on edge N does not affect that read.
REQ-030 rd_addr >= DEPTH SHALL return rd_data all-zero with rd_valid=1.
REQ-031 rd_valid SHALL be 0 in any cycle without a matching rd_en two edges earlier.
REQ-032 Loads and reads SHALL proceed concurrently without stalls; banks are disjoint, so no collision exists.

Reset
REQ-033 On rst=0: active_bank=0, shadow_full=0, load_ready=0 while asserted, rd_valid=0, rd_data=0, FSM=FILL, wr_row=0, beat counter=0, read pipeline flushed.
REQ-034 Bank contents SHALL NOT be cleared by reset; reset mid-load discards the partial row.
REQ-035 load_ready SHALL be 1 on the first edge after rst deasserts.

Verification
REQ-036 Reset release, 6 beats of elements 0..23 -> bank 1 row 0 written; shadow_full stays 0, load_ready 1.
REQ-037 Full load 16384 beats (2730 rows + 4 beats, no load_last) -> shadow_full=1 after row 2730 written, row 2730 lanes 16..23 zero, load_ready=0.
REQ-038 After REQ-037, swap=1 -> active_bank=1, shadow_full=0; rd_en rd_addr=0 -> rd_valid two cycles later, rd_data=elements 0..23.
REQ-039 3 beats then load_last=1 on beat 4 -> row 0 lanes 0..15 loaded, lanes 16..23 zero, shadow_full=1; swap in FILL beforehand -> active_bank unchanged.
REQ-040 Back-to-back rd_en, rd_addr 0,1,4095 with swap on second request -> 3 consecutive rd_valid; first two from old bank, third all-zero (out-of-range).
REQ-041 rst=0 asserted mid-row (beat 3) -> all outputs per REQ-033 asynchronously; prior bank contents readable after release.
